// File: rtl/imm_extend_pkg.sv
// Shared types and defaults for the decode-stage immediate extension unit.
package imm_extend_pkg;

  typedef enum logic [1:0] {
    IMM_SIGN   = 2'd0,
    IMM_ZERO   = 2'd1,
    IMM_UPPER  = 2'd2,
    IMM_BRANCH = 2'd3
  } imm_mode_t;

  typedef enum logic [1:0] {
    SK_EMPTY = 2'd0,
    SK_ONE   = 2'd1,
    SK_TWO   = 2'd2
  } skid_state_t;

  localparam int BR_SHIFT_DEFAULT = 2;

endpackage

// File: rtl/imm_extend_core.sv
// Combinational immediate extension: sign, zero, upper (lui) and shifted branch offset.
module imm_extend_core
  import imm_extend_pkg::*;
#(
  parameter int IN_W     = 16,
  parameter int OUT_W    = 32,
  parameter int BR_SHIFT = BR_SHIFT_DEFAULT
) (
  input  logic [IN_W-1:0]  imm_i,
  input  imm_mode_t        mode_i,
  output logic [OUT_W-1:0] ext_o
);

  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] zext;
  logic [OUT_W-1:0] upper;

  // Built by overlay rather than replication so IN_W == OUT_W stays legal.
  always_comb begin
    sext               = {OUT_W{imm_i[IN_W-1]}};
    sext[IN_W-1:0]     = imm_i;
    zext               = '0;
    zext[IN_W-1:0]     = imm_i;
    upper              = '0;
    upper[OUT_W-1 -: IN_W] = imm_i;
  end

  always_comb begin
    ext_o = sext;
    case (mode_i)
      IMM_SIGN:   ext_o = sext;
      IMM_ZERO:   ext_o = zext;
      IMM_UPPER:  ext_o = upper;
      IMM_BRANCH: ext_o = sext << BR_SHIFT;
      default:    ext_o = sext;
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate extension stage with a 2-entry skid buffer and flush.
//   state    | meaning
//   SK_EMPTY | nothing buffered; in_ready=1, out_valid=0
//   SK_ONE   | main holds the output entry; in_ready=1, out_valid=1
//   SK_TWO   | main and skid both full; in_ready=0, out_valid=1
module imm_extend_pipe
  import imm_extend_pkg::*;
#(
  parameter int IN_W     = 16,
  parameter int OUT_W    = 32,
  parameter int TAG_W    = 5,
  parameter int BR_SHIFT = BR_SHIFT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  imm_mode_t        in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_imm,
  output logic [TAG_W-1:0] out_tag
);

  skid_state_t      state_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [OUT_W-1:0] main_imm_q;
  logic [TAG_W-1:0] main_tag_q;
  logic [OUT_W-1:0] skid_imm_q;
  logic [TAG_W-1:0] skid_tag_q;
  logic [OUT_W-1:0] ext;
  logic             in_xfer;
  logic             out_xfer;

  imm_extend_core #(
    .IN_W    (IN_W),
    .OUT_W   (OUT_W),
    .BR_SHIFT(BR_SHIFT)
  ) u_core (
    .imm_i (in_imm),
    .mode_i(in_mode),
    .ext_o (ext)
  );

  assign in_xfer  = in_valid && in_ready_q;
  assign out_xfer = out_valid_q && out_ready;

  // Flush only resets control state; stale data is unreachable once out_valid drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SK_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      main_imm_q  <= '0;
      main_tag_q  <= '0;
      skid_imm_q  <= '0;
      skid_tag_q  <= '0;
    end else if (flush) begin
      state_q     <= SK_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        SK_EMPTY: begin
          if (in_xfer) begin
            main_imm_q  <= ext;
            main_tag_q  <= in_tag;
            out_valid_q <= 1'b1;
            state_q     <= SK_ONE;
          end
        end
        SK_ONE: begin
          if (in_xfer && out_xfer) begin
            main_imm_q <= ext;
            main_tag_q <= in_tag;
          end else if (in_xfer) begin
            skid_imm_q <= ext;
            skid_tag_q <= in_tag;
            in_ready_q <= 1'b0;
            state_q    <= SK_TWO;
          end else if (out_xfer) begin
            out_valid_q <= 1'b0;
            state_q     <= SK_EMPTY;
          end
        end
        SK_TWO: begin
          if (out_xfer) begin
            main_imm_q <= skid_imm_q;
            main_tag_q <= skid_tag_q;
            in_ready_q <= 1'b1;
            state_q    <= SK_ONE;
          end
        end
        default: begin
          state_q     <= SK_EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_imm   = main_imm_q;
  assign out_tag   = main_tag_q;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe: default 16->32 instance plus a 12->64 instance.
module tb_imm_extend_pipe;
  import imm_extend_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, flush, in_valid, out_ready;
  logic [15:0] in_imm;
  imm_mode_t   in_mode;
  logic [4:0]  in_tag;
  logic        in_ready, out_valid;
  logic [31:0] out_imm;
  logic [4:0]  out_tag;

  logic        w_flush, w_in_valid, w_out_ready;
  logic [11:0] w_in_imm;
  imm_mode_t   w_in_mode;
  logic [4:0]  w_in_tag;
  logic        w_in_ready, w_out_valid;
  logic [63:0] w_out_imm;
  logic [4:0]  w_out_tag;

  int n_checks = 0;
  int n_fails  = 0;

  imm_extend_pipe dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm),
    .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_imm(out_imm), .out_tag(out_tag)
  );

  imm_extend_pipe #(.IN_W(12), .OUT_W(64), .TAG_W(5), .BR_SHIFT(1)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(w_flush),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .in_imm(w_in_imm),
    .in_mode(w_in_mode), .in_tag(w_in_tag),
    .out_valid(w_out_valid), .out_ready(w_out_ready),
    .out_imm(w_out_imm), .out_tag(w_out_tag)
  );

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] imm, input imm_mode_t m, input logic [4:0] t);
    in_valid = v;
    in_imm   = imm;
    in_mode  = m;
    in_tag   = t;
  endtask

  task automatic drive64(input logic v, input logic [11:0] imm, input imm_mode_t m, input logic [4:0] t);
    w_in_valid = v;
    w_in_imm   = imm;
    w_in_mode  = m;
    w_in_tag   = t;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 16'h0, IMM_SIGN, 5'd0);
    w_flush = 1'b0; w_out_ready = 1'b0;
    drive64(1'b0, 12'h0, IMM_SIGN, 5'd0);
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_out_imm",   64'(out_imm),   64'd0);
    check("rst_out_tag",   64'(out_tag),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Extension modes, streaming with out_ready=1
    out_ready = 1'b1;
    drive(1'b1, 16'h8001, IMM_SIGN, 5'd3);
    step();
    check("sign_valid", 64'(out_valid), 64'd1);
    check("sign_imm",   64'(out_imm),   64'h0000_0000_FFFF_8001);
    check("sign_tag",   64'(out_tag),   64'd3);
    drive(1'b1, 16'h8001, IMM_ZERO, 5'd4);
    step();
    check("zero_imm", 64'(out_imm), 64'h0000_8001);
    check("zero_tag", 64'(out_tag), 64'd4);
    drive(1'b1, 16'h1234, IMM_UPPER, 5'd5);
    step();
    check("upper_imm", 64'(out_imm), 64'h1234_0000);
    drive(1'b1, 16'hFFFF, IMM_BRANCH, 5'd6);
    step();
    check("branch_neg_imm", 64'(out_imm), 64'hFFFF_FFFC);
    drive(1'b1, 16'h7FFF, IMM_BRANCH, 5'd7);
    step();
    check("branch_pos_imm", 64'(out_imm), 64'h0001_FFFC);
    check("branch_pos_tag", 64'(out_tag), 64'd7);
    drive(1'b0, 16'h0, IMM_SIGN, 5'd0);
    step();
    check("drain_valid", 64'(out_valid), 64'd0);

    // Backpressure: fill both entries, hold, then drain in order
    out_ready = 1'b0;
    drive(1'b1, 16'd1, IMM_ZERO, 5'd1);
    step();
    check("bp1_in_ready", 64'(in_ready), 64'd1);
    drive(1'b1, 16'd2, IMM_ZERO, 5'd2);
    step();
    check("bp2_in_ready", 64'(in_ready), 64'd0);
    check("bp2_tag",      64'(out_tag),  64'd1);
    drive(1'b1, 16'd3, IMM_ZERO, 5'd3);
    step();
    check("bp_hold_tag",   64'(out_tag),   64'd1);
    check("bp_hold_imm",   64'(out_imm),   64'd1);
    check("bp_hold_ready", 64'(in_ready),  64'd0);
    step();
    check("bp_hold2_tag",  64'(out_tag),   64'd1);
    check("bp_hold2_vld",  64'(out_valid), 64'd1);
    out_ready = 1'b1;
    step();
    check("bp_out2_tag",   64'(out_tag),  64'd2);
    check("bp_out2_imm",   64'(out_imm),  64'd2);
    check("bp_out2_ready", 64'(in_ready), 64'd1);
    step();
    check("bp_out3_tag",   64'(out_tag),  64'd3);
    drive(1'b0, 16'h0, IMM_SIGN, 5'd0);
    step();
    check("bp_done_valid", 64'(out_valid), 64'd0);

    // Full throughput
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, 16'(i), IMM_ZERO, 5'(i));
      step();
      check("thru_imm",   64'(out_imm),   64'(i));
      check("thru_tag",   64'(out_tag),   64'(i % 32));
      check("thru_valid", 64'(out_valid), 64'd1);
      check("thru_ready", 64'(in_ready),  64'd1);
    end
    drive(1'b0, 16'h0, IMM_SIGN, 5'd0);
    step();
    check("thru_end_valid", 64'(out_valid), 64'd0);

    // Flush in TWO with a concurrent input
    out_ready = 1'b0;
    drive(1'b1, 16'd10, IMM_ZERO, 5'd10);
    step();
    drive(1'b1, 16'd11, IMM_ZERO, 5'd11);
    step();
    check("fl_two_ready", 64'(in_ready), 64'd0);
    flush = 1'b1;
    drive(1'b1, 16'd12, IMM_ZERO, 5'd12);
    step();
    flush = 1'b0;
    drive(1'b0, 16'h0, IMM_SIGN, 5'd0);
    check("fl_valid", 64'(out_valid), 64'd0);
    check("fl_ready", 64'(in_ready),  64'd1);
    out_ready = 1'b1;
    step();
    check("fl_stay_empty1", 64'(out_valid), 64'd0);
    step();
    check("fl_stay_empty2", 64'(out_valid), 64'd0);
    drive(1'b1, 16'd13, IMM_ZERO, 5'd13);
    step();
    check("fl_next_tag", 64'(out_tag), 64'd13);
    check("fl_next_imm", 64'(out_imm), 64'd13);
    // Flush in ONE drops an input that in_ready would have accepted
    out_ready = 1'b0;
    flush = 1'b1;
    drive(1'b1, 16'd15, IMM_ZERO, 5'd15);
    step();
    flush = 1'b0;
    drive(1'b0, 16'h0, IMM_SIGN, 5'd0);
    check("fl_one_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    step();
    check("fl_one_stay", 64'(out_valid), 64'd0);

    // Asynchronous reset between edges while in TWO
    out_ready = 1'b0;
    drive(1'b1, 16'h00AA, IMM_ZERO, 5'd20);
    step();
    drive(1'b1, 16'h00BB, IMM_ZERO, 5'd21);
    step();
    drive(1'b0, 16'h0, IMM_SIGN, 5'd0);
    check("ar_pre_ready", 64'(in_ready), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid", 64'(out_valid), 64'd0);
    check("ar_ready", 64'(in_ready),  64'd1);
    check("ar_imm",   64'(out_imm),   64'd0);
    check("ar_tag",   64'(out_tag),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 16'h8001, IMM_SIGN, 5'd7);
    step();
    check("ar_post_imm", 64'(out_imm), 64'h0000_0000_FFFF_8001);
    check("ar_post_tag", 64'(out_tag), 64'd7);
    drive(1'b0, 16'h0, IMM_SIGN, 5'd0);
    step();
    check("ar_post_drain", 64'(out_valid), 64'd0);

    // 12->64 instance, BR_SHIFT=1
    w_out_ready = 1'b1;
    drive64(1'b1, 12'h800, IMM_SIGN, 5'd1);
    step();
    check("w_sign_imm", w_out_imm, 64'hFFFF_FFFF_FFFF_F800);
    check("w_sign_tag", 64'(w_out_tag), 64'd1);
    drive64(1'b1, 12'h800, IMM_ZERO, 5'd2);
    step();
    check("w_zero_imm", w_out_imm, 64'h0000_0000_0000_0800);
    drive64(1'b1, 12'hABC, IMM_UPPER, 5'd3);
    step();
    check("w_upper_imm", w_out_imm, 64'hABC0_0000_0000_0000);
    drive64(1'b1, 12'h800, IMM_BRANCH, 5'd4);
    step();
    check("w_branch_neg", w_out_imm, 64'hFFFF_FFFF_FFFF_F000);
    drive64(1'b1, 12'h7FF, IMM_BRANCH, 5'd5);
    step();
    check("w_branch_pos", w_out_imm, 64'h0000_0000_0000_0FFE);
    check("w_branch_tag", 64'(w_out_tag), 64'd5);
    check("w_ready",      64'(w_in_ready), 64'd1);
    drive64(1'b0, 12'h0, IMM_SIGN, 5'd0);
    step();
    check("w_drain", 64'(w_out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
